xbar_id_order_tracker: RTL

XBAR_ID_ORDER_TRACKER -- requirements
Module: xbar_id_order_tracker

---
 rtl/xbar_id_order_tracker.sv | 100 ++++++++++
 1 files changed

// File: rtl/xbar_id_order_tracker.sv
// Per-ID ordering tracker for a crossbar master port: a transaction may only issue
// if every outstanding transaction with its ID targets the same slave.
// Optional sticky retire-underflow flag: define XBAR_ID_TRACKER_UNDERFLOW_ERR_EN.

module xbar_id_slot #(
  parameter int SDW = 1,
  parameter int CW  = 3
) (
  input  logic           ACLK,
  input  logic           ARESETn,
  input  logic           inc,
  input  logic           dec,
  input  logic [SDW-1:0] dest,
  output logic [CW-1:0]  cnt,
  output logic [SDW-1:0] dst
);
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      cnt <= '0;
      dst <= '0;
    end else begin
      if (inc && !dec)      cnt <= cnt + CW'(1);
      else if (dec && !inc) cnt <= cnt - CW'(1);
      // dst is left stale when cnt drains; it is only consulted while cnt != 0
      if (inc) dst <= dest;
    end
  end
endmodule

module xbar_id_order_tracker #(
  parameter int ID_WIDTH   = 4,
  parameter int slaves     = 2,
  parameter int MAX_PER_ID = 4,
  parameter int MAX_TOTAL  = 8,
  parameter int SDW        = $clog2(slaves),
  parameter int CW         = $clog2(MAX_PER_ID+1),
  parameter int TW         = $clog2(MAX_TOTAL+1)
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                req_valid,
  input  logic [ID_WIDTH-1:0] req_id,
  input  logic [SDW-1:0]      req_dest,
  input  logic                req_ready,
  output logic                req_grant,
  input  logic                rsp_valid,
  input  logic [ID_WIDTH-1:0] rsp_id,
  input  logic                rsp_last,
  output logic [TW-1:0]       total_outstanding,
  output logic                busy
`ifdef XBAR_ID_TRACKER_UNDERFLOW_ERR_EN
  ,
  output logic                underflow_err
`endif
);
  localparam int NID = 1 << ID_WIDTH;

  logic [NID-1:0][CW-1:0]  cnt;
  logic [NID-1:0][SDW-1:0] dst;
  logic [NID-1:0]          inc, dec;
  logic [CW-1:0]           req_cnt, rsp_cnt;
  logic [SDW-1:0]          req_dst;
  logic                    allowed, retire, ret_ok;

  assign req_cnt = cnt[req_id];
  assign req_dst = dst[req_id];
  assign rsp_cnt = cnt[rsp_id];

  assign allowed   = (req_cnt == '0 || (req_dst == req_dest && req_cnt < CW'(MAX_PER_ID)))
                     && total_outstanding < TW'(MAX_TOTAL);
  assign req_grant = req_valid & req_ready & allowed;

  // A retire against an empty counter is dropped so nothing wraps
  assign retire = rsp_valid & rsp_last;
  assign ret_ok = retire && rsp_cnt != '0 && total_outstanding != '0;

  for (genvar i = 0; i < NID; i++) begin : g_id
    assign inc[i] = req_grant && req_id == ID_WIDTH'(i);
    assign dec[i] = ret_ok && rsp_id == ID_WIDTH'(i);
    xbar_id_slot #(.SDW(SDW), .CW(CW)) u_slot (
      .ACLK(ACLK), .ARESETn(ARESETn), .inc(inc[i]), .dec(dec[i]),
      .dest(req_dest), .cnt(cnt[i]), .dst(dst[i])
    );
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn)              total_outstanding <= '0;
    else if (req_grant && !ret_ok) total_outstanding <= total_outstanding + TW'(1);
    else if (ret_ok && !req_grant) total_outstanding <= total_outstanding - TW'(1);
  end

  assign busy = total_outstanding != '0;

`ifdef XBAR_ID_TRACKER_UNDERFLOW_ERR_EN
  always_ff @(posedge ACLK) begin
    if (!ARESETn) underflow_err <= 1'b0;
    else if (retire && (rsp_cnt == '0 || total_outstanding == '0)) underflow_err <= 1'b1;
  end
`endif
endmodule
